// File: rtl/wdt_kick_master.sv
// Bus master that programs the system watchdog and keeps it kicked
// while the host heartbeat stays alive.
module wdt_kick_master #(
  parameter int unsigned MM_ADDR_WIDTH = 8,
  parameter int unsigned MM_DATA_WIDTH = 16,
  parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_SWDT_CTRL = 'h0A,
  parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_SWDT_VAL  = 'h0C,
  localparam int unsigned TW = 13,
  localparam int unsigned KW = 16
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_n_i,
  output logic [MM_ADDR_WIDTH-1:0] mm_m_addr_o,
  output logic [MM_DATA_WIDTH-1:0] mm_m_wdata_o,
  input  logic [MM_DATA_WIDTH-1:0] mm_m_rdata_i,
  output logic                     mm_m_we_o,
  input  logic                     clk_8hz_i,
  input  logic                     cfg_en_i,
  input  logic [TW-1:0]            cfg_timeout_i,
  input  logic [TW-1:0]            cfg_kick_div_i,
  input  logic                     host_alive_i,
  input  logic                     wdt_ot_i,
  output logic                     busy_o,
  output logic                     err_o,
  output logic                     starve_o,
  output logic                     ot_seen_o,
  output logic [KW-1:0]            kick_cnt_o
);

  localparam logic [MM_DATA_WIDTH-1:0] CTRL_KICK = MM_DATA_WIDTH'(16'h5A01);
  localparam logic [MM_DATA_WIDTH-1:0] CTRL_DIS  = MM_DATA_WIDTH'(16'h2700);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_WR,
    ST_CFG_RD,
    ST_EN_WR,
    ST_RUN,
    ST_KICK_WR,
    ST_KICK_RD,
    ST_DIS_WR,
    ST_ERR
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            clk8_q;
  logic            tick;
  logic            alive_q;
  logic [TW-1:0]   div_cnt;
  logic [TW-1:0]   div_eff;
  logic [TW-1:0]   timeout_q;
  logic            div_expire;

  // Readback only ever inspects the low bits; the rest is don't-care.
  logic            unused_rdata;
  assign unused_rdata = ^mm_m_rdata_i[MM_DATA_WIDTH-1:TW];

  assign tick       = clk_8hz_i & ~clk8_q;
  assign div_eff    = (cfg_kick_div_i == '0) ? TW'(1) : cfg_kick_div_i;
  assign div_expire = tick && (div_cnt <= TW'(1));

  // Next-state decode; a dropped enable redirects any busy state to DIS_WR.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (cfg_en_i) state_nxt = ST_CFG_WR;
      ST_CFG_WR:  state_nxt = cfg_en_i ? ST_CFG_RD : ST_DIS_WR;
      ST_CFG_RD: begin
        if (!cfg_en_i)                                state_nxt = ST_DIS_WR;
        else if (mm_m_rdata_i[TW-1:0] != timeout_q)   state_nxt = ST_ERR;
        else                                          state_nxt = ST_EN_WR;
      end
      ST_EN_WR:   state_nxt = cfg_en_i ? ST_RUN : ST_DIS_WR;
      ST_RUN: begin
        if (!cfg_en_i)                  state_nxt = ST_DIS_WR;
        else if (div_expire && alive_q) state_nxt = ST_KICK_WR;
      end
      ST_KICK_WR: state_nxt = cfg_en_i ? ST_KICK_RD : ST_DIS_WR;
      ST_KICK_RD: begin
        if (!cfg_en_i)            state_nxt = ST_DIS_WR;
        else if (!mm_m_rdata_i[0]) state_nxt = ST_ERR;
        else                      state_nxt = ST_RUN;
      end
      ST_DIS_WR:  state_nxt = ST_IDLE;
      ST_ERR:     if (!cfg_en_i) state_nxt = ST_DIS_WR;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State, bus outputs, divider, alive latch and sticky flags.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= ST_IDLE;
      clk8_q       <= 1'b0;
      alive_q      <= 1'b0;
      div_cnt      <= '0;
      timeout_q    <= '0;
      mm_m_addr_o  <= '0;
      mm_m_wdata_o <= '0;
      mm_m_we_o    <= 1'b0;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
      starve_o     <= 1'b0;
      ot_seen_o    <= 1'b0;
      kick_cnt_o   <= '0;
    end else begin
      state     <= state_nxt;
      clk8_q    <= clk_8hz_i;
      busy_o    <= !(state_nxt inside {ST_IDLE, ST_RUN, ST_ERR});
      err_o     <= (state_nxt == ST_ERR);
      mm_m_we_o <= 1'b0;

      unique case (state_nxt)
        ST_CFG_WR: begin
          mm_m_we_o    <= 1'b1;
          mm_m_addr_o  <= REG_ADDR_SWDT_VAL;
          mm_m_wdata_o <= MM_DATA_WIDTH'(cfg_timeout_i);
          timeout_q    <= cfg_timeout_i;
          starve_o     <= 1'b0;
          kick_cnt_o   <= '0;
          ot_seen_o    <= 1'b0;
        end
        ST_CFG_RD:  mm_m_addr_o <= REG_ADDR_SWDT_VAL;
        ST_EN_WR: begin
          mm_m_we_o    <= 1'b1;
          mm_m_addr_o  <= REG_ADDR_SWDT_CTRL;
          mm_m_wdata_o <= CTRL_KICK;
        end
        ST_KICK_WR: begin
          mm_m_we_o    <= 1'b1;
          mm_m_addr_o  <= REG_ADDR_SWDT_CTRL;
          mm_m_wdata_o <= CTRL_KICK;
          kick_cnt_o   <= kick_cnt_o + KW'(1);
        end
        ST_KICK_RD: mm_m_addr_o <= REG_ADDR_SWDT_CTRL;
        ST_DIS_WR: begin
          mm_m_we_o    <= 1'b1;
          mm_m_addr_o  <= REG_ADDR_SWDT_CTRL;
          mm_m_wdata_o <= CTRL_DIS;
        end
        default: ;
      endcase

      if (wdt_ot_i) ot_seen_o <= 1'b1;

      if (state == ST_EN_WR) begin
        div_cnt <= div_eff;
      end else if (state == ST_RUN && tick) begin
        if (div_cnt <= TW'(1)) begin
          div_cnt <= div_eff;
          if (cfg_en_i && !alive_q) starve_o <= 1'b1;
        end else begin
          div_cnt <= div_cnt - TW'(1);
        end
      end

      // A pulse arriving on the kick cycle is kept for the next interval.
      if (host_alive_i)                 alive_q <= 1'b1;
      else if (state_nxt == ST_KICK_WR) alive_q <= 1'b0;
    end
  end

endmodule
